msgpu_framebuffer_controller: RTL and testbench
===============================================

Name: msgpu_framebuffer_controller

Overview:
- Sits between the MCU bus receiver and the single-port framebuffer RAM in msgpu.
- Parses command/data bytes into framebuffer writes (set address, stream pixels, fill screen) and queues them in a write FIFO.
- Arbitrates the one RAM port: VGA pixel reads have strict priority, and queued writes drain in idle cycles.

Parameters:
- ADDRESS_WIDTH, 22: framebuffer address width.
- DATA_WIDTH, 8: pixel/byte width.
- FIFO_DEPTH, 4: write FIFO entries; must be a power of 2, ≥2.
- FRAMEBUFFER_SIZE, 76800: pixel count; addresses wrap at FRAMEBUFFER_SIZE-1 → 0.

Ports:
- system_clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- bus_valid  in  1  byte present on bus_data (already synchronised to system_clock).
- bus_command_data  in  1  1 = command byte, 0 = data byte.
- bus_data  in  8  byte from MCU bus.
- bus_ready  out  1  byte accepted in a cycle where bus_valid && bus_ready.
- vga_read_request  in  1  VGA wants the pixel at vga_read_address.
- vga_read_address  in  ADDRESS_WIDTH  VGA read address.
- vga_read_data  out  DATA_WIDTH  returned pixel.
- vga_read_valid  out  1  vga_read_data valid this cycle.
- mem_address  out  ADDRESS_WIDTH  RAM address (registered).
- mem_write_data  out  DATA_WIDTH  RAM write data (registered).
- mem_write_enable  out  1  RAM write strobe (registered).
- mem_read_data  in  DATA_WIDTH  RAM sync read data, one cycle after address.
- busy  out  1  FIFO non-empty or FSM in FILLING.
- error  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - All registered outputs and internal registers are 0.
  - FSM is IDLE and the FIFO is empty.
  - bus_ready = 1 and busy = 0 while reset is held.
- bus_ready is asserted when the FIFO is not full and the state is not FILLING.
  - While bus_ready is low, the MCU holds its byte.
- Opcodes (command bytes):
  - 0x00 NOP.
  - 0x01 SET_ADDRESS.
  - 0x02 WRITE.
  - 0x03 FILL.
  - 0x04 CLEAR_ERROR.
  - Any other opcode sets error and returns to IDLE.
- FSM states: IDLE, ADDR0, ADDR1, ADDR2, WRITE, FILL_COLOR, FILLING.
  - IDLE: a data byte is dropped and sets error.
  - SET_ADDRESS → ADDR0. Collects 3 data bytes, MSB first, into a 24-bit value; the low ADDRESS_WIDTH bits are loaded into the write pointer after the 3rd byte, then → IDLE. Values ≥ FRAMEBUFFER_SIZE are loaded as 0 and set error.
  - WRITE: each data byte pushes {pointer, byte} into the FIFO. The pointer then increments, wrapping from FRAMEBUFFER_SIZE-1 to 0. The state persists until the next command byte.
  - FILL → FILL_COLOR. The next data byte latches the colour → FILLING.
    - FILLING pushes {fill_counter, colour} on every cycle the FIFO is not full, counting 0..FRAMEBUFFER_SIZE-1. After the last push → IDLE.
    - The write pointer is unchanged by FILL.
  - A command byte in ADDR0–ADDR2 or FILL_COLOR aborts the sequence and sets error; the new command is then decoded normally in the same cycle. A partial address is discarded.
  - CLEAR_ERROR clears error. An error event in the same cycle wins.
- Arbitration, evaluated every cycle:
  - If vga_read_request is high: mem_address <= vga_read_address and mem_write_enable <= 0.
  - Else if the FIFO is non-empty: pop the FIFO, mem_address/mem_write_data <= entry and mem_write_enable <= 1.
  - Else mem_write_enable <= 0, and mem_address/mem_write_data hold their values.
- VGA latency:
  - A request in cycle N yields vga_read_valid = 1 and vga_read_data = mem_read_data in cycle N+2.
  - vga_read_valid is a registered 2-stage pipe of the grant.
  - VGA reads are never stalled; back-to-back requests give back-to-back data.
- Writes can starve under continuous VGA requests; the VGA blanking intervals guarantee draining. This is intended.
- FIFO ordering is strict, so writes reach RAM in acceptance order.
  - A push and a pop in the same cycle are legal when the FIFO is non-empty.
  - A push while full never occurs, because of bus_ready gating.
- Reset asserted mid-FILL or mid-WRITE:
  - The FIFO is flushed and the FSM returns to IDLE.
  - Writes already issued to RAM remain.

Decomposition:
- msgpu_pkg:
  - opcode localparams (OP_NOP, OP_SET_ADDRESS, OP_WRITE, OP_FILL, OP_CLEAR_ERROR);
  - FSM state encoding;
  - the FIFO entry width (ADDRESS_WIDTH+DATA_WIDTH).
- Sub-module msgpu_write_fifo: synchronous FIFO with push, pop, full, empty; async active-high reset; parameterised on width and depth.

Test Plan:
1. SET_ADDRESS 0x00,0x01,0x00, then WRITE, then data 0xAA,0xBB with no VGA requests:
   - mem_write_enable pulses with address 0x100/data 0xAA, then 0x101/0xBB;
   - busy returns to 0 and error stays 0.
2. SET_ADDRESS to FRAMEBUFFER_SIZE-1, then WRITE 0x11,0x22 → writes land at 76799, then 0.
3. Continuous vga_read_request for 8 cycles while writing 4 data bytes:
   - bus_ready drops after the 4 FIFO entries;
   - no mem_write_enable during the requests, and vga_read_valid matches each request at N+2;
   - the 4 writes drain in order after the requests stop.
4. FILL, data 0x5C with FRAMEBUFFER_SIZE=16 override:
   - exactly 16 writes, addresses 0..15, all data 0x5C;
   - bus_ready is 0 until the last push, then the FSM is IDLE.
5. Protocol errors and recovery:
   - SET_ADDRESS, data 0x01, then a WRITE command: error=1, the pointer is unchanged, and the WRITE state is entered.
   - Opcode 0x7F sets error.
   - CLEAR_ERROR → error=0.
   - A data byte in IDLE → error=1.
6. Reset asserted during FILL with a full FIFO:
   - all outputs return to reset values immediately (asynchronously);
   - after release, bus_ready=1, busy=0 and no further writes occur.

Source files
------------

// File: rtl/msgpu_pkg.sv
// Shared definitions for the msgpu framebuffer controller: bus opcodes,
// command-parser states and the write FIFO entry layout.
package msgpu_pkg;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_SET_ADDRESS = 8'h01;
    localparam logic [7:0] OP_WRITE       = 8'h02;
    localparam logic [7:0] OP_FILL        = 8'h03;
    localparam logic [7:0] OP_CLEAR_ERROR = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR0,
        ST_ADDR1,
        ST_ADDR2,
        ST_WRITE,
        ST_FILL_COLOR,
        ST_FILLING
    } fb_state_t;

    // A FIFO entry is {address, pixel}, address in the upper bits.
    function automatic int fifo_entry_width(input int address_width, input int data_width);
        return address_width + data_width;
    endfunction

endpackage

// File: rtl/msgpu_write_fifo.sv
// Synchronous FIFO holding pending framebuffer writes; DEPTH must be a power of 2.
// Pushes while full and pops while empty are ignored.
module msgpu_write_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             system_clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    logic [WIDTH-1:0]   storage [DEPTH];
    logic [PTR_W-1:0]   write_index;
    logic [PTR_W-1:0]   read_index;
    logic [COUNT_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == COUNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = storage[read_index];

    // Indices wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            write_index <= '0;
            read_index  <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (do_push) begin
                storage[write_index] <= push_data;
                write_index          <= write_index + 1'b1;
            end
            if (do_pop) begin
                read_index <= read_index + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msgpu_framebuffer_controller.sv
// Turns MCU command/data bytes into queued framebuffer writes and shares the
// single RAM port with VGA reads, which always take priority.
module msgpu_framebuffer_controller
    import msgpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 22,
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH       = 4,
    parameter int FRAMEBUFFER_SIZE = 76800
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     bus_valid,
    input  logic                     bus_command_data,
    input  logic [7:0]               bus_data,
    output logic                     bus_ready,
    input  logic                     vga_read_request,
    input  logic [ADDRESS_WIDTH-1:0] vga_read_address,
    output logic [DATA_WIDTH-1:0]    vga_read_data,
    output logic                     vga_read_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic                     busy,
    output logic                     error
);

    localparam int ENTRY_WIDTH = fifo_entry_width(ADDRESS_WIDTH, DATA_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(FRAMEBUFFER_SIZE - 1);
    localparam logic [23:0] SIZE_24 = 24'(FRAMEBUFFER_SIZE);

    fb_state_t                state, next_state;
    logic [ADDRESS_WIDTH-1:0] write_pointer, next_write_pointer;
    logic [ADDRESS_WIDTH-1:0] fill_counter, next_fill_counter;
    logic [15:0]              address_high, next_address_high;
    logic [DATA_WIDTH-1:0]    fill_colour, next_fill_colour;
    logic [23:0]              collected_address;
    logic                     set_error, clear_error;
    logic                     byte_accepted, command_byte, data_byte;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_WIDTH-1:0]   push_entry, pop_entry;
    logic                     vga_grant_d1;

    function automatic logic [ADDRESS_WIDTH-1:0] advance(input logic [ADDRESS_WIDTH-1:0] a);
        return (a == LAST_ADDRESS) ? '0 : a + 1'b1;
    endfunction

    assign bus_ready     = !fifo_full && (state != ST_FILLING);
    assign busy          = !fifo_empty || (state == ST_FILLING);
    assign byte_accepted = bus_valid && bus_ready;
    assign command_byte  = byte_accepted && bus_command_data;
    assign data_byte     = byte_accepted && !bus_command_data;
    assign fifo_pop      = !vga_read_request && !fifo_empty;
    assign vga_read_data = vga_read_valid ? mem_read_data : '0;

    msgpu_write_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_write_fifo (
        .system_clock (system_clock),
        .reset        (reset),
        .push         (fifo_push),
        .push_data    (push_entry),
        .pop          (fifo_pop),
        .pop_data     (pop_entry),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    // Command parser; an aborted sequence flags error but the new opcode still decodes.
    always_comb begin
        next_state         = state;
        next_write_pointer = write_pointer;
        next_fill_counter  = fill_counter;
        next_address_high  = address_high;
        next_fill_colour   = fill_colour;
        set_error          = 1'b0;
        clear_error        = 1'b0;
        fifo_push          = 1'b0;
        push_entry         = '0;
        collected_address  = {address_high, bus_data};

        if (command_byte) begin
            if (state inside {ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_FILL_COLOR}) begin
                set_error = 1'b1;
            end
            case (bus_data)
                OP_NOP:         next_state = ST_IDLE;
                OP_SET_ADDRESS: next_state = ST_ADDR0;
                OP_WRITE:       next_state = ST_WRITE;
                OP_FILL:        next_state = ST_FILL_COLOR;
                OP_CLEAR_ERROR: begin
                    clear_error = 1'b1;
                    next_state  = ST_IDLE;
                end
                default: begin
                    set_error  = 1'b1;
                    next_state = ST_IDLE;
                end
            endcase
        end else if (data_byte) begin
            case (state)
                ST_IDLE:  set_error = 1'b1;
                ST_ADDR0: begin
                    next_address_high = {8'h00, bus_data};
                    next_state        = ST_ADDR1;
                end
                ST_ADDR1: begin
                    next_address_high = {address_high[7:0], bus_data};
                    next_state        = ST_ADDR2;
                end
                ST_ADDR2: begin
                    if (collected_address >= SIZE_24) begin
                        next_write_pointer = '0;
                        set_error          = 1'b1;
                    end else begin
                        next_write_pointer = ADDRESS_WIDTH'(collected_address);
                    end
                    next_state = ST_IDLE;
                end
                ST_WRITE: begin
                    fifo_push          = 1'b1;
                    push_entry         = {write_pointer, DATA_WIDTH'(bus_data)};
                    next_write_pointer = advance(write_pointer);
                end
                ST_FILL_COLOR: begin
                    next_fill_colour  = DATA_WIDTH'(bus_data);
                    next_fill_counter = '0;
                    next_state        = ST_FILLING;
                end
                default: ;
            endcase
        end else if (state == ST_FILLING && !fifo_full) begin
            fifo_push  = 1'b1;
            push_entry = {fill_counter, fill_colour};
            if (fill_counter == LAST_ADDRESS) begin
                next_fill_counter = '0;
                next_state        = ST_IDLE;
            end else begin
                next_fill_counter = fill_counter + 1'b1;
            end
        end
    end

    // Error is sticky; a new error event beats CLEAR_ERROR in the same cycle.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            write_pointer <= '0;
            fill_counter  <= '0;
            address_high  <= '0;
            fill_colour   <= '0;
            error         <= 1'b0;
        end else begin
            state         <= next_state;
            write_pointer <= next_write_pointer;
            fill_counter  <= next_fill_counter;
            address_high  <= next_address_high;
            fill_colour   <= next_fill_colour;
            if (set_error) begin
                error <= 1'b1;
            end else if (clear_error) begin
                error <= 1'b0;
            end
        end
    end

    // RAM port arbiter; the grant pipe lines vga_read_valid up with sync-read data.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            vga_grant_d1     <= 1'b0;
            vga_read_valid   <= 1'b0;
        end else begin
            vga_grant_d1   <= vga_read_request;
            vga_read_valid <= vga_grant_d1;
            if (vga_read_request) begin
                mem_address      <= vga_read_address;
                mem_write_enable <= 1'b0;
            end else if (!fifo_empty) begin
                mem_address      <= pop_entry[ENTRY_WIDTH-1 -: ADDRESS_WIDTH];
                mem_write_data   <= pop_entry[DATA_WIDTH-1:0];
                mem_write_enable <= 1'b1;
            end else begin
                mem_write_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msgpu_framebuffer_controller.sv
// Directed bench: a full-size instance for address/VGA/protocol tests and a
// 16-pixel instance for FILL; sel routes the shared stimulus to one of them.
module tb_msgpu_framebuffer_controller;

    logic        system_clock = 1'b0;
    logic        reset;
    logic        sel;
    logic        bus_valid;
    logic        bus_command_data;
    logic [7:0]  bus_data;
    logic        vga_read_request;
    logic [21:0] vga_read_address;
    logic [7:0]  mem_read_data = 8'h00;

    logic        big_bus_ready, big_vga_read_valid, big_mem_write_enable, big_busy, big_error;
    logic [7:0]  big_vga_read_data, big_mem_write_data;
    logic [21:0] big_mem_address;
    logic        small_bus_ready, small_vga_read_valid, small_mem_write_enable, small_busy, small_error;
    logic [7:0]  small_vga_read_data, small_mem_write_data;
    logic [21:0] small_mem_address;

    logic        bus_ready, vga_read_valid, mem_write_enable, busy, error;
    logic [7:0]  vga_read_data, mem_write_data;
    logic [21:0] mem_address;

    int checks   = 0;
    int failures = 0;

    logic [21:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    always #5 system_clock = ~system_clock;

    msgpu_framebuffer_controller dut_big (
        .system_clock     (system_clock),
        .reset            (reset),
        .bus_valid        (bus_valid && !sel),
        .bus_command_data (bus_command_data),
        .bus_data         (bus_data),
        .bus_ready        (big_bus_ready),
        .vga_read_request (vga_read_request && !sel),
        .vga_read_address (vga_read_address),
        .vga_read_data    (big_vga_read_data),
        .vga_read_valid   (big_vga_read_valid),
        .mem_address      (big_mem_address),
        .mem_write_data   (big_mem_write_data),
        .mem_write_enable (big_mem_write_enable),
        .mem_read_data    (mem_read_data),
        .busy             (big_busy),
        .error            (big_error)
    );

    msgpu_framebuffer_controller #(.FRAMEBUFFER_SIZE(16)) dut_small (
        .system_clock     (system_clock),
        .reset            (reset),
        .bus_valid        (bus_valid && sel),
        .bus_command_data (bus_command_data),
        .bus_data         (bus_data),
        .bus_ready        (small_bus_ready),
        .vga_read_request (vga_read_request && sel),
        .vga_read_address (vga_read_address),
        .vga_read_data    (small_vga_read_data),
        .vga_read_valid   (small_vga_read_valid),
        .mem_address      (small_mem_address),
        .mem_write_data   (small_mem_write_data),
        .mem_write_enable (small_mem_write_enable),
        .mem_read_data    (mem_read_data),
        .busy             (small_busy),
        .error            (small_error)
    );

    assign bus_ready        = sel ? small_bus_ready        : big_bus_ready;
    assign vga_read_valid   = sel ? small_vga_read_valid   : big_vga_read_valid;
    assign vga_read_data    = sel ? small_vga_read_data    : big_vga_read_data;
    assign mem_address      = sel ? small_mem_address      : big_mem_address;
    assign mem_write_data   = sel ? small_mem_write_data   : big_mem_write_data;
    assign mem_write_enable = sel ? small_mem_write_enable : big_mem_write_enable;
    assign busy             = sel ? small_busy             : big_busy;
    assign error            = sel ? small_error            : big_error;

    // RAM stand-in: sync read returning a fixed function of the address.
    always @(posedge system_clock) mem_read_data <= mem_address[7:0] ^ 8'hA5;

    always @(negedge system_clock) begin
        if (!reset && mem_write_enable) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_write_data);
        end
    end

    task automatic send_byte(input logic cmd, input logic [7:0] value);
        int waited = 0;
        bus_valid = 1'b1; bus_command_data = cmd; bus_data = value;
        while (!bus_ready && waited < 100) begin
            @(negedge system_clock);
            waited++;
        end
        if (!bus_ready) begin
            checks++; failures++;
            $display("[TB] FAIL send_timeout: bus_ready got %b required 1", bus_ready);
        end else begin
            @(negedge system_clock);
        end
        bus_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int waited = 0;
        while (busy && waited < budget) begin
            @(negedge system_clock);
            waited++;
        end
        if (busy) begin
            checks++; failures++;
            $display("[TB] FAIL wait_idle: busy got %b required 0", busy);
        end
        repeat (2) @(negedge system_clock);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; sel = 1'b0; bus_valid = 1'b0; bus_command_data = 1'b0; bus_data = 8'h00;
        vga_read_request = 1'b0; vga_read_address = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge system_clock);
        checks++; if (bus_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_bus_ready: got %b required 1", bus_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error: got %b required 0", error); end
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b required 0", mem_write_enable); end
        checks++; if (mem_address !== 22'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h required 0", mem_address); end
        checks++; if (vga_read_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_vga_valid: got %b required 0", vga_read_valid); end
        reset = 1'b0;
        @(negedge system_clock);
    endtask

    task automatic test_write_stream();
        logic [21:0] exp_addr [2] = '{22'h100, 22'h101};
        logic [7:0]  exp_data [2] = '{8'hAA, 8'hBB};
        sel = 1'b0;
        clear_log();
        send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h00);
        send_byte(1'b1, 8'h02); send_byte(1'b0, 8'hAA); send_byte(1'b0, 8'hBB);
        wait_idle(20);
        checks++; if (wr_addr_q.size() !== 2) begin failures++; $display("[TB] FAIL stream_count: got %0d required 2", wr_addr_q.size()); end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                failures++; $display("[TB] FAIL stream_write%0d: got %h/%h required %h/%h", i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stream_busy: got %b required 0", busy); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL stream_error: got %b required 0", error); end
    endtask

    task automatic test_address_wrap();
        logic [21:0] exp_addr [2] = '{22'd76799, 22'd0};
        logic [7:0]  exp_data [2] = '{8'h11, 8'h22};
        sel = 1'b0;
        clear_log();
        send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h2B); send_byte(1'b0, 8'hFF);
        send_byte(1'b1, 8'h02); send_byte(1'b0, 8'h11); send_byte(1'b0, 8'h22);
        wait_idle(20);
        checks++; if (wr_addr_q.size() !== 2) begin failures++; $display("[TB] FAIL wrap_count: got %0d required 2", wr_addr_q.size()); end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                failures++; $display("[TB] FAIL wrap_write%0d: got %h/%h required %h/%h", i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL wrap_error: got %b required 0", error); end
    endtask

    task automatic test_vga_priority();
        logic [21:0] base = 22'h40;
        logic [21:0] req_addr;
        logic        exp_valid;
        logic [7:0]  exp_byte;
        sel = 1'b0;
        send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h02); send_byte(1'b0, 8'h00);
        send_byte(1'b1, 8'h02);
        wait_idle(20);
        clear_log();
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    exp_valid = (i >= 2) && (i - 2 < 8);
                    checks++; if (vga_read_valid !== exp_valid) begin
                        failures++; $display("[TB] FAIL vga_valid_%0d: got %b required %b", i, vga_read_valid, exp_valid);
                    end
                    if (exp_valid) begin
                        req_addr = base + 22'(i - 2);
                        exp_byte = req_addr[7:0] ^ 8'hA5;
                        checks++; if (vga_read_data !== exp_byte) begin
                            failures++; $display("[TB] FAIL vga_data_%0d: got %h required %h", i, vga_read_data, exp_byte);
                        end
                    end
                    if (i >= 1 && i <= 8) begin
                        checks++; if (mem_write_enable !== 1'b0) begin
                            failures++; $display("[TB] FAIL vga_blocks_write_%0d: got %b required 0", i, mem_write_enable);
                        end
                    end
                    if (i < 8) begin
                        vga_read_request = 1'b1;
                        vga_read_address = base + 22'(i);
                    end else begin
                        vga_read_request = 1'b0;
                    end
                    @(negedge system_clock);
                end
            end
            begin
                for (int b = 0; b < 4; b++) send_byte(1'b0, 8'hC0 + 8'(b));
                checks++; if (bus_ready !== 1'b0) begin failures++; $display("[TB] FAIL fifo_full_ready: got %b required 0", bus_ready); end
            end
        join
        wait_idle(20);
        checks++; if (wr_addr_q.size() !== 4) begin failures++; $display("[TB] FAIL drain_count: got %0d required 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== 22'h200 + 22'(i) || wr_data_q[i] !== 8'hC0 + 8'(i)) begin
                failures++; $display("[TB] FAIL drain_write%0d: got %h/%h required %h/%h", i, wr_addr_q[i], wr_data_q[i], 22'h200 + 22'(i), 8'hC0 + 8'(i));
            end
        end
    endtask

    task automatic test_fill();
        int low_cycles = 0;
        sel = 1'b1;
        clear_log();
        send_byte(1'b1, 8'h03); send_byte(1'b0, 8'h5C);
        while (!bus_ready && low_cycles < 100) begin
            low_cycles++;
            @(negedge system_clock);
        end
        checks++; if (low_cycles !== 16) begin failures++; $display("[TB] FAIL fill_ready_low: got %0d cycles required 16", low_cycles); end
        wait_idle(20);
        checks++; if (wr_addr_q.size() !== 16) begin failures++; $display("[TB] FAIL fill_count: got %0d required 16", wr_addr_q.size()); end
        for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== 22'(i) || wr_data_q[i] !== 8'h5C) begin
                failures++; $display("[TB] FAIL fill_write%0d: got %h/%h required %h/5c", i, wr_addr_q[i], wr_data_q[i], 22'(i));
            end
        end
        checks++; if (bus_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL fill_idle: got ready=%b busy=%b required 1/0", bus_ready, busy);
        end
    endtask

    task automatic test_protocol_errors();
        sel = 1'b0;
        clear_log();
        send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h01); send_byte(1'b1, 8'h02);
        checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL abort_error: got %b required 1", error); end
        send_byte(1'b0, 8'h33);
        wait_idle(20);
        checks++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 22'h204 || wr_data_q[0] !== 8'h33) begin
            failures++; $display("[TB] FAIL abort_pointer: got %0d writes first %h required 1 write at 000204", wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 22'h3FFFFF);
        end
        send_byte(1'b1, 8'h04);
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL clear1: got %b required 0", error); end
        send_byte(1'b1, 8'h7F);
        checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL bad_opcode: got %b required 1", error); end
        send_byte(1'b1, 8'h04);
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL clear2: got %b required 0", error); end
        clear_log();
        send_byte(1'b0, 8'h99);
        checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL idle_data: got %b required 1", error); end
        repeat (3) @(negedge system_clock);
        checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL idle_data_write: got %0d writes required 0", wr_addr_q.size()); end
        send_byte(1'b1, 8'h04);
    endtask

    task automatic test_reset_during_fill();
        sel = 1'b1;
        vga_read_request = 1'b1;
        vga_read_address = 22'h3;
        send_byte(1'b1, 8'h03); send_byte(1'b0, 8'h5C);
        repeat (8) @(negedge system_clock);
        checks++; if (bus_ready !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL prefill_state: got ready=%b busy=%b required 0/1", bus_ready, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus_ready !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            failures++; $display("[TB] FAIL async_reset_flags: got ready=%b busy=%b error=%b required 1/0/0", bus_ready, busy, error);
        end
        checks++; if (mem_write_enable !== 1'b0 || mem_address !== 22'h0 || vga_read_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL async_reset_port: got we=%b addr=%h valid=%b required 0/0/0", mem_write_enable, mem_address, vga_read_valid);
        end
        vga_read_request = 1'b0;
        @(negedge system_clock);
        reset = 1'b0;
        clear_log();
        repeat (30) @(negedge system_clock);
        checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL post_reset_writes: got %0d required 0", wr_addr_q.size()); end
        checks++; if (bus_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset_idle: got ready=%b busy=%b required 1/0", bus_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_stream();
        test_address_wrap();
        test_vga_priority();
        test_fill();
        test_protocol_errors();
        test_reset_during_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
